// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared definitions for the RTC bus arbiter: requester indices, FSM states,
// per-requester transaction record and the register-index to bus-address map.
package rtc_bus_arbiter_pkg;

  localparam int NUM_REQ = 3;
  localparam int REQ_IRQ = 0;
  localparam int REQ_USR = 1;
  localparam int REQ_REF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP
  } arb_state_e;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  // Index 0 is the status register, 7 the transfer command, 1..6 map to 0x21..0x26.
  localparam logic [7:0][7:0] ADDR_MAP = {
    8'hF0, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h00
  };

endpackage

// File: rtl/rtc_arb_prio.sv
// Fixed-priority winner select (0 > 1 > 2) with a starvation override that
// hands the grant to the refresh requester.
module rtc_arb_prio
  import rtc_bus_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_ref,
  output logic [NUM_REQ-1:0] win
);

  always_comb begin
    win = '0;
    if (force_ref && req[REQ_REF]) win[REQ_REF] = 1'b1;
    else if (req[REQ_IRQ])         win[REQ_IRQ] = 1'b1;
    else if (req[REQ_USR])         win[REQ_USR] = 1'b1;
    else if (req[REQ_REF])         win[REQ_REF] = 1'b1;
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Shares the single RTC transaction engine among IRQ service, user writes and
// display refresh; one transaction at a time with timeout and inter-transaction gap.
module rtc_bus_arbiter
  import rtc_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int GAP     = 4,
  parameter int STARVE  = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  REQ,
  input  logic [2:0]  WR,
  input  logic [8:0]  ADDR,
  input  logic [23:0] WDATA,
  output logic [2:0]  GNT,
  output logic [2:0]  DONE,
  output logic [7:0]  RDATA,
  output logic        ERR,
  output logic        ENG_START,
  output logic        ENG_WR,
  output logic [7:0]  ENG_ADDR,
  output logic [7:0]  ENG_WDATA,
  input  logic [7:0]  ENG_RDATA,
  input  logic        FRW
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  arb_state_e         state_q, state_d;
  txn_t               txn_q, txn_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic               start_q, start_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic [1:0]         starve_q, starve_d;

  txn_t [NUM_REQ-1:0] cand;
  txn_t               sel;
  logic [NUM_REQ-1:0] win;
  logic               force_ref;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cand
    assign cand[i] = '{wr:    WR[i],
                       addr:  ADDR_MAP[ADDR[3*i +: 3]],
                       wdata: WDATA[8*i +: 8]};
  end

  assign force_ref = (int'(starve_q) == STARVE);

  rtc_arb_prio u_prio (
    .req       (REQ),
    .force_ref (force_ref),
    .win       (win)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win[i]) sel = cand[i];
  end

  always_comb begin
    state_d    = state_q;
    txn_d      = txn_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    err_d      = 1'b0;
    start_d    = 1'b0;
    rdata_d    = rdata_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    starve_d   = starve_q;
    case (state_q)
      ST_IDLE: begin
        // Refresh idle or just served: the starvation history no longer matters.
        if (!REQ[REQ_REF] || win[REQ_REF]) starve_d = '0;
        else if (starve_q != 2'd3)         starve_d = starve_q + 2'd1;
        if (|REQ) begin
          txn_d   = sel;
          owner_d = win;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_d    = 1'b1;
        gnt_d      = owner_q;
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (FRW) begin
          done_d    = owner_q;
          gnt_d     = '0;
          if (!txn_q.wr) rdata_d = ENG_RDATA;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else if (wait_cnt_q == TMO_LAST) begin
          done_d    = owner_q;
          err_d     = 1'b1;
          gnt_d     = '0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      txn_q      <= '0;
      owner_q    <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      txn_q      <= txn_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      start_q    <= start_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      starve_q   <= starve_d;
    end
  end

  assign GNT       = gnt_q;
  assign DONE      = done_q;
  assign RDATA     = rdata_q;
  assign ERR       = err_q;
  assign ENG_START = start_q;
  assign ENG_WR    = txn_q.wr;
  assign ENG_ADDR  = txn_q.addr;
  assign ENG_WDATA = txn_q.wdata;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed scoreboard bench: stimulus queues expected start/done records, a
// negedge monitor pops and compares them whenever the DUT presents START or DONE.
module tb_rtc_bus_arbiter;

  localparam int TIMEOUT = 255;
  localparam int GAP     = 4;
  localparam int STARVE  = 3;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  REQ, WR, GNT, DONE;
  logic [8:0]  ADDR;
  logic [23:0] WDATA;
  logic [7:0]  RDATA, ENG_ADDR, ENG_WDATA, ENG_RDATA;
  logic        ERR, ENG_START, ENG_WR, FRW;

  always #5 CLK = ~CLK;

  rtc_bus_arbiter #(.TIMEOUT(TIMEOUT), .GAP(GAP), .STARVE(STARVE)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WR(WR), .ADDR(ADDR), .WDATA(WDATA),
    .GNT(GNT), .DONE(DONE), .RDATA(RDATA), .ERR(ERR),
    .ENG_START(ENG_START), .ENG_WR(ENG_WR), .ENG_ADDR(ENG_ADDR),
    .ENG_WDATA(ENG_WDATA), .ENG_RDATA(ENG_RDATA), .FRW(FRW)
  );

  typedef struct packed {
    logic [2:0] g;
    logic       wr;
    logic [7:0] a;
    logic [7:0] wd;
  } st_exp_t;

  typedef struct packed {
    logic [2:0] d;
    logic [7:0] rd;
    logic       err;
    int         lat;
  } dn_exp_t;

  st_exp_t st_q[$];
  dn_exp_t dn_q[$];

  int   n_cmp = 0, n_bad = 0;
  int   wait_fail = 0;
  logic chk_rst = 1'b0, end_req = 1'b0;
  logic [7:0] exp_rdata = 8'h00;

  // ---------------- monitor / scoreboard ----------------
  int   cyc = 0, start_cyc = 0, last_done = 0, wf_seen = 0;
  logic have_done = 1'b0;

  always @(negedge CLK) begin
    st_exp_t se;
    dn_exp_t de;
    logic [32:0] got;
    cyc++;
    if (chk_rst) begin
      got = {GNT, DONE, ERR, ENG_START, ENG_WR, ENG_ADDR, ENG_WDATA, RDATA};
      n_cmp++;
      if (got != 33'd0) begin
        n_bad++;
        $display("FAIL reset_outputs got=%h want=0", got);
      end
    end
    if (wait_fail != wf_seen) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_bound expired count=%0d want=%0d", wait_fail, wf_seen);
      wf_seen = wait_fail;
    end
    if (ENG_START) begin
      n_cmp++;
      if (st_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_start gnt=%b addr=%h", GNT, ENG_ADDR);
      end else begin
        se = st_q.pop_front();
        if ({GNT, ENG_WR, ENG_ADDR, ENG_WDATA} !== se) begin
          n_bad++;
          $display("FAIL start_fields got gnt=%b wr=%b addr=%h wd=%h want gnt=%b wr=%b addr=%h wd=%h",
                   GNT, ENG_WR, ENG_ADDR, ENG_WDATA, se.g, se.wr, se.a, se.wd);
        end
      end
      if (have_done) begin
        n_cmp++;
        if (cyc - last_done < GAP + 2) begin
          n_bad++;
          $display("FAIL start_gap got=%0d want>=%0d", cyc - last_done, GAP + 2);
        end
      end
      start_cyc = cyc;
    end
    if (DONE != 3'b000) begin
      n_cmp++;
      if (dn_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done done=%b", DONE);
      end else begin
        de = dn_q.pop_front();
        if ({DONE, RDATA, ERR, GNT} !== {de.d, de.rd, de.err, 3'b000}) begin
          n_bad++;
          $display("FAIL done_fields got done=%b rdata=%h err=%b gnt=%b want done=%b rdata=%h err=%b gnt=000",
                   DONE, RDATA, ERR, GNT, de.d, de.rd, de.err);
        end
        n_cmp++;
        if (cyc - start_cyc != de.lat) begin
          n_bad++;
          $display("FAIL done_latency got=%0d want=%0d", cyc - start_cyc, de.lat);
        end
      end
      last_done = cyc;
      have_done = 1'b1;
    end
    if (end_req) begin
      n_cmp++;
      if (st_q.size() + dn_q.size() != 0) begin
        n_bad++;
        $display("FAIL leftover_expect got=%0d want=0", st_q.size() + dn_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_exp(input logic [2:0] g, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, input int dly, input logic [7:0] rd);
    st_q.push_back('{g: g, wr: wr, a: a, wd: wd});
    if (dly < 0) begin
      dn_q.push_back('{d: g, rd: exp_rdata, err: 1'b1, lat: TIMEOUT});
    end else begin
      if (!wr) exp_rdata = rd;
      dn_q.push_back('{d: g, rd: exp_rdata, err: 1'b0, lat: dly + 1});
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!ENG_START && n < 50) begin @(negedge CLK); n++; end
    if (!ENG_START) wait_fail++;
  endtask

  task automatic wait_done();
    int n = 0;
    while (DONE == 3'b000 && n < 400) begin @(negedge CLK); n++; end
    if (DONE == 3'b000) wait_fail++;
  endtask

  // Plays the engine: FRW (with read data) dly cycles after START; dly<0 never answers.
  task automatic serve(input int dly, input logic [7:0] rd);
    wait_start();
    if (dly >= 0) begin
      repeat (dly) @(negedge CLK);
      FRW = 1'b1; ENG_RDATA = rd;
      @(negedge CLK);
      FRW = 1'b0;
    end
    wait_done();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    RST = 1'b0; REQ = '0; WR = '0; ADDR = '0; WDATA = '0; FRW = 1'b0; ENG_RDATA = '0;
    chk_rst = 1'b1;
    repeat (2) @(posedge CLK);
    chk_rst = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // single read of the status register
    WDATA = 24'h0000A5;
    push_exp(3'b001, 1'b0, 8'h00, 8'hA5, 5, 8'h5A);
    REQ = 3'b001; serve(5, 8'h5A); REQ = 3'b000;

    // all three pending: 0,1,0 then forced refresh grant
    ADDR = {3'd1, 3'd2, 3'd4}; WDATA = 24'h332211;
    push_exp(3'b001, 1'b0, 8'h24, 8'h11, 2, 8'hA1);
    REQ = 3'b111; serve(2, 8'hA1); REQ = 3'b110;
    push_exp(3'b010, 1'b0, 8'h22, 8'h22, 2, 8'hA2);
    serve(2, 8'hA2); REQ = 3'b101;
    push_exp(3'b001, 1'b0, 8'h24, 8'h11, 2, 8'hA3);
    serve(2, 8'hA3); REQ = 3'b111;
    push_exp(3'b100, 1'b0, 8'h21, 8'h33, 2, 8'hA4);
    serve(2, 8'hA4); REQ = 3'b000;

    // user write leaves RDATA alone
    WR = 3'b010; ADDR = {3'd0, 3'd3, 3'd0}; WDATA = 24'h001200;
    push_exp(3'b010, 1'b1, 8'h23, 8'h12, 3, 8'hEE);
    REQ = 3'b010; serve(3, 8'hEE); REQ = 3'b000; WR = 3'b000;

    // engine never answers: timeout
    ADDR = 9'd6; WDATA = 24'h0;
    push_exp(3'b001, 1'b0, 8'h26, 8'h00, -1, 8'h00);
    REQ = 3'b001; serve(-1, 8'h00); REQ = 3'b000;

    // normal traffic afterwards
    ADDR = 9'd7;
    push_exp(3'b001, 1'b0, 8'hF0, 8'h00, 1, 8'hC3);
    REQ = 3'b001; serve(1, 8'hC3); REQ = 3'b000;

    // FRW on the very timeout cycle wins
    ADDR = 9'd0;
    push_exp(3'b100, 1'b0, 8'h00, 8'h00, TIMEOUT - 1, 8'h3C);
    REQ = 3'b100; serve(TIMEOUT - 1, 8'h3C); REQ = 3'b000;

    // FRW during ISSUE is ignored; the pulse 3 cycles later completes
    ADDR = 9'd2;
    repeat (GAP + 3) @(negedge CLK);
    push_exp(3'b001, 1'b0, 8'h22, 8'h00, 2, 8'h77);
    REQ = 3'b001;
    @(negedge CLK); FRW = 1'b1; ENG_RDATA = 8'h11;
    @(negedge CLK); FRW = 1'b0;
    repeat (2) @(negedge CLK);
    FRW = 1'b1; ENG_RDATA = 8'h77;
    @(negedge CLK); FRW = 1'b0;
    wait_done(); REQ = 3'b000;

    // reset while waiting on the engine: no DONE, everything cleared at once
    ADDR = 9'd5;
    st_q.push_back('{g: 3'b001, wr: 1'b0, a: 8'h25, wd: 8'h00});
    REQ = 3'b001;
    wait_start();
    repeat (3) @(negedge CLK);
    @(posedge CLK); #2;
    RST = 1'b0; REQ = 3'b000; chk_rst = 1'b1;
    @(posedge CLK);
    chk_rst = 1'b0;
    @(negedge CLK);
    RST = 1'b1; exp_rdata = 8'h00;
    @(negedge CLK);

    ADDR = {3'd4, 6'd0};
    push_exp(3'b100, 1'b0, 8'h24, 8'h00, 0, 8'h9C);
    REQ = 3'b100; serve(0, 8'h9C); REQ = 3'b000;

    repeat (10) @(negedge CLK);
    end_req = 1'b1;
  end

endmodule
